// File: rtl/subneg_pkg.sv
// Shared types and default address helpers for the SUBNEG core.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package subneg_pkg;

  typedef enum logic [2:0] {
    HALT,
    FETCH_A,
    FETCH_B,
    FETCH_C,
    READ_A,
    READ_B,
    EXEC
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  // Output register sits at the top word of the address space.
  function automatic int def_out_addr(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

  // Input port sits just below the output register.
  function automatic int def_in_addr(input int addr_w);
    return (1 << addr_w) - 2;
  endfunction

endpackage

// File: rtl/subneg_if.sv
// Control, load, I/O and status bundle between the TT wrapper and the core.
// Latency: wires only.
// Backpressure: none; load/start are only honoured while the core is halted.
interface subneg_if
  import subneg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              start;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              busy;
  logic [ADDR_W-1:0] pc;

  // Wrapper / bench side: drives control and load, observes results.
  modport master (
    output start, load_en, load_addr, load_data, in_data,
    input  out_data, out_valid, busy, pc
  );

  // Core side.
  modport slave (
    input  start, load_en, load_addr, load_data, in_data,
    output out_data, out_valid, busy, pc
  );
endinterface

// File: rtl/subneg_mem.sv
// Program/data memory: 2**ADDR_W words, one combinational read, one write port.
// Latency: read is combinational, write lands on the next rising edge.
// Backpressure: none; the core guarantees load and exec writes never collide.
module subneg_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              exec_we,
  input  logic [ADDR_W-1:0] exec_addr,
  input  logic [DATA_W-1:0] exec_data,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  // Not reset: program contents must survive a core reset.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // Single write port shared by the loader (HALT only) and EXEC.
  always_comb begin
    we    = load_we | exec_we;
    waddr = load_we ? load_addr : exec_addr;
    wdata = load_we ? load_data : exec_data;
  end

  // Synchronous write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/subneg_core.sv
// SUBLEQ-style core: mem[B] -= mem[A], branch to C on borrow; halts on a taken jump-to-self.
// Latency: 6 cycles per instruction; out_data/out_valid update on the EXEC edge.
// Backpressure: none; load_en/start ignored while busy. Macro SUBNEG_IN_PORT_EN maps in_data at IN_ADDR.
module subneg_core
  import subneg_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int OUT_ADDR = def_out_addr(ADDR_W),
  parameter int IN_ADDR  = def_in_addr(ADDR_W)
) (
  input logic      clk,
  input logic      reset,
  subneg_if.slave  bus
);
  localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_ADDR);

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_a, addr_b, addr_c;
  logic [DATA_W-1:0] val_a, val_b;
  logic [DATA_W-1:0] out_q;
  logic              out_vld_q;

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W:0]   diff;
  logic              borrow;
  logic [DATA_W-1:0] result;
  logic              wr_is_out;
  logic              wr_dropped;
  logic              exec_we;
  logic              load_we;

  // Single read port: the address follows the instruction phase.
  always_comb begin
    rd_addr = pc_q;
    case (state)
      FETCH_A: rd_addr = pc_q;
      FETCH_B: rd_addr = pc_q + ADDR_W'(1);
      FETCH_C: rd_addr = pc_q + ADDR_W'(2);
      READ_A:  rd_addr = addr_a;
      READ_B:  rd_addr = addr_b;
      default: rd_addr = pc_q;
    endcase
  end

`ifdef SUBNEG_IN_PORT_EN
  localparam logic [ADDR_W-1:0] IN_A = ADDR_W'(IN_ADDR);

  // Memory-mapped reads: output register readback and live input port.
  always_comb begin
    rd_data = mem_rdata;
    if (rd_addr == OUT_A) begin
      rd_data = out_q;
    end else if (rd_addr == IN_A) begin
      rd_data = bus.in_data;
    end
  end

  assign wr_dropped = (addr_b == IN_A);
`else
  // Memory-mapped reads: output register readback only.
  always_comb begin
    rd_data = mem_rdata;
    if (rd_addr == OUT_A) rd_data = out_q;
  end

  assign wr_dropped = 1'b0;

  logic unused_in_data;
  assign unused_in_data = ^bus.in_data;
`endif

  // Borrow is the extra top bit of a widened subtract.
  assign diff   = {1'b0, val_b} - {1'b0, val_a};
  assign borrow = diff[DATA_W];
  assign result = diff[DATA_W-1:0];

  assign wr_is_out = (addr_b == OUT_A);

  // Reset gates both write sources so an aborted EXEC leaves memory untouched.
  assign exec_we = (state == EXEC) && !reset && !wr_is_out && !wr_dropped;
  assign load_we = (state == HALT) && !reset && bus.load_en;

  subneg_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .load_we   (load_we),
    .load_addr (bus.load_addr),
    .load_data (bus.load_data),
    .exec_we   (exec_we),
    .exec_addr (addr_b),
    .exec_data (result),
    .raddr     (rd_addr),
    .rdata     (mem_rdata)
  );

  // Instruction sequencer: fetch three address words, read two operands, execute.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HALT;
      pc_q      <= '0;
      addr_a    <= '0;
      addr_b    <= '0;
      addr_c    <= '0;
      val_a     <= '0;
      val_b     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= 1'b0;
      case (state)
        HALT: begin
          if (bus.start) begin
            pc_q  <= '0;
            state <= FETCH_A;
          end
        end
        FETCH_A: begin
          addr_a <= rd_data[ADDR_W-1:0];
          state  <= FETCH_B;
        end
        FETCH_B: begin
          addr_b <= rd_data[ADDR_W-1:0];
          state  <= FETCH_C;
        end
        FETCH_C: begin
          addr_c <= rd_data[ADDR_W-1:0];
          state  <= READ_A;
        end
        READ_A: begin
          val_a <= rd_data;
          state <= READ_B;
        end
        READ_B: begin
          val_b <= rd_data;
          state <= EXEC;
        end
        EXEC: begin
          if (wr_is_out) begin
            out_q     <= result;
            out_vld_q <= 1'b1;
          end
          if (borrow) begin
            pc_q  <= addr_c;
            // A taken jump to the current instruction would spin forever: stop instead.
            state <= (addr_c == pc_q) ? HALT : FETCH_A;
          end else begin
            pc_q  <= pc_q + ADDR_W'(3);
            state <= FETCH_A;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  assign bus.busy      = (state != HALT);
  assign bus.pc        = pc_q;
  assign bus.out_data  = out_q;
  assign bus.out_valid = out_vld_q;

endmodule
